// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instr_fetch_unit_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// rtl/instr_fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [63:0] d_pc,
    input  logic [31:0] d_instr,
    output logic        valid,
    output logic [63:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Flush only drops the valid bit; the stale payload is harmless once invalid.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = d_pc;
            instr_d = d_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= 64'd0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-issue instruction fetch stage with redirect and fault handling
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] pc,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output logic        fault,
    output logic [63:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [63:0] LAST_FETCH_PC = 64'(MEM_BYTES) - 64'(INSTR_BYTES);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [63:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic id_load, id_flush;
    logic can_advance, target_misaligned, pc_out_of_range;

    assign can_advance       = !id_valid || id_ready;
    assign target_misaligned = redirect_target[1:0] != 2'b00;
    assign pc_out_of_range   = pc_q > LAST_FETCH_PC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            fault_q       <= 1'b0;
            fault_pc_q    <= 64'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    if (target_misaligned) state_d = ST_FAULT;
                end else if (can_advance && pc_out_of_range) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RUN;
        endcase
    end

    // Redirect wins over advance/stall; FAULT freezes everything until reset.
    always_comb begin
        pc_d          = pc_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;
        id_load       = 1'b0;
        id_flush      = 1'b0;
        if (state_q == ST_RUN) begin
            if (redirect_valid) begin
                id_flush = 1'b1;
                if (target_misaligned) begin
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_target;
                end else begin
                    pc_d = redirect_target;
                end
            end else if (can_advance) begin
                if (pc_out_of_range) begin
                    id_flush   = 1'b1;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_q;
                end else begin
                    id_load       = 1'b1;
                    pc_d          = pc_q + 64'(INSTR_BYTES);
                    fetch_count_d = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q
                                                                     : fetch_count_q + 32'd1;
                end
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (id_load),
        .flush   (id_flush),
        .d_pc    (pc_q),
        .d_instr (instr_in),
        .valid   (id_valid),
        .pc      (id_pc),
        .instr   (id_instr)
    );

    assign pc          = pc_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = fetch_count_q;

endmodule
